// File: rtl/reg_file_wb_pkg.sv
// Shared processor package: architectural widths and the MEM/WB writeback trunk.
// Both the register file and its load scoreboard import these definitions.
package reg_file_wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef struct packed {
    logic              RegWrite;
    logic [REG_AW-1:0] Rd;
    logic [XLEN-1:0]   Result;
  } Memory_Bundle;

  // True when the writeback trunk commits a value to the given non-zero register.
  function automatic logic wb_hits(input Memory_Bundle b, input logic [REG_AW-1:0] addr);
    return b.RegWrite && (b.Rd != '0) && (b.Rd == addr);
  endfunction

endpackage

// File: rtl/reg_file_wb_load_scoreboard.sv
// Per-register busy tracking for outstanding loads; drives the decode-stage stall.
// A load issued on the same edge as a writeback to that register leaves it busy.
module load_scoreboard #(
  parameter int NREG = reg_file_wb_pkg::NREG
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_we,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] wb_rd,
  input  logic                             ld_issue,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] ld_rd,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] rs1_addr,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] rs2_addr,
  output logic                             rs1_busy,
  output logic                             rs2_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // Clear first, then set, so a newer load overrides the completing one.
  always_comb begin
    busy_next = busy;
    if (wb_we) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (ld_issue && (ld_rd != '0)) begin
      busy_next[ld_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A writeback arriving this cycle satisfies the dependency without waiting an edge.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (!rst) begin
      rs1_busy = busy[rs1_addr] && !(wb_we && (wb_rd == rs1_addr));
      rs2_busy = busy[rs2_addr] && !(wb_we && (wb_rd == rs2_addr));
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file with write-through bypass from MEM/WB and a
// load-use scoreboard that generates the decode stall.
module reg_file_wb #(
  parameter int XLEN = reg_file_wb_pkg::XLEN,
  parameter int NREG = reg_file_wb_pkg::NREG
) (
  input  logic                               clk,
  input  logic                               rst,
  input  reg_file_wb_pkg::Memory_Bundle      wb,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] rs1_addr,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]                    rs1_data,
  output logic [XLEN-1:0]                    rs2_data,
  input  logic                               ld_issue,
  input  logic [reg_file_wb_pkg::REG_AW-1:0] ld_rd,
  output logic                               rs1_busy,
  output logic                               rs2_busy,
  output logic                               stall
);

  import reg_file_wb_pkg::*;

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;
  logic [XLEN-1:0] wb_value;

  assign wr_en    = wb.RegWrite && (wb.Rd != '0);
  assign wb_value = XLEN'(wb.Result);

  // x0 is never written, so its storage stays at the reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wb.Rd] <= wb_value;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (!rst) begin
      if (wb_hits(wb, rs1_addr)) begin
        rs1_data = wb_value;
      end else if (rs1_addr != '0) begin
        rs1_data = regs[rs1_addr];
      end
      if (wb_hits(wb, rs2_addr)) begin
        rs2_data = wb_value;
      end else if (rs2_addr != '0) begin
        rs2_data = regs[rs2_addr];
      end
    end
  end

  load_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb.RegWrite),
    .wb_rd    (wb.Rd),
    .ld_issue (ld_issue),
    .ld_rd    (ld_rd),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  assign stall = rs1_busy | rs2_busy;

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 Parameter XLEN, default 32, data width of each architectural register.
REQ-002 Parameter NREG, default 32, register count; address width is $clog2(NREG).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wb  input  Memory_Bundle  writeback trunk from the MEM/WB register; fields used: RegWrite (1), Rd (5), Result (XLEN).
REQ-006 rs1_addr, rs2_addr  input  5 each  decode-stage source register addresses.
REQ-007 rs1_data, rs2_data  output  XLEN each  source operand values.
REQ-008 ld_issue  input  1  decode stage issuing a load this cycle.
REQ-009 ld_rd  input  5  destination register of the issuing load.
REQ-010 rs1_busy, rs2_busy  output  1 each  source register awaits an outstanding load.
REQ-011 stall  output  1  decode must hold; equals rs1_busy OR rs2_busy.

Function
REQ-012 The block SHALL hold NREG x XLEN registers, written only on a rising clk edge with wb.RegWrite=1 and wb.Rd!=0.
REQ-013 Register x0 SHALL read 0 at all times; writes to Rd=0 SHALL be discarded with no state change.
REQ-014 Reads SHALL be combinational: rsN_data = reg[rsN_addr].
REQ-015 Write-through bypass: when wb.RegWrite=1, wb.Rd!=0 and wb.Rd==rsN_addr, rsN_data SHALL equal wb.Result in the same cycle (zero-cycle read-after-write).
REQ-016 Both read ports SHALL bypass independently; both ports SHALL return wb.Result when both addresses match wb.Rd.
REQ-017 The block SHALL keep one busy bit per register (scoreboard); bit 0 SHALL always read 0.
REQ-018 On an edge with ld_issue=1 and ld_rd!=0, busy[ld_rd] SHALL be set.
REQ-019 On an edge with wb.RegWrite=1, busy[wb.Rd] SHALL be cleared.
REQ-020 Simultaneous set and clear of the same register SHALL leave busy set (a newer load wins).
REQ-021 rsN_busy = busy[rsN_addr] AND NOT (wb.RegWrite AND wb.Rd==rsN_addr), so a same-cycle writeback releases the stall.
REQ-022 stall SHALL be combinational, with no added latency.
REQ-023 Only the busy-bit state for a given register is tracked; a second ld_issue to a busy register SHALL keep it busy with no error indication.

Reset
REQ-024 Asserting rst SHALL immediately clear all registers and all busy bits, independent of clk.
REQ-025 While rst=1: rsN_data=0, rsN_busy=0, stall=0, and writes and ld_issue SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL discard any pending writeback in the same cycle.
REQ-027 The first write SHALL take effect on the first rising edge after rst deasserts.

Structure
REQ-028 Memory_Bundle, XLEN and the register-address width SHALL come from the shared processor package; this block SHALL add no new typedefs.
REQ-029 The scoreboard SHALL be a sub-module named load_scoreboard, containing REQ-017 to REQ-021 and REQ-023.
REQ-030 Register storage and bypass SHALL stay in reg_file_wb.

Verification
REQ-031 Reset then read all 32 addresses -> every rsN_data=0, stall=0.
REQ-032 Write Rd=5, Result=0xDEADBEEF, with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF before the edge; after the edge, reg[5] still reads 0xDEADBEEF.
REQ-033 Write Rd=0, Result=0xFFFFFFFF -> rs1_addr=0 reads 0 in the write cycle and afterwards.
REQ-034 ld_issue with ld_rd=7, then rs2_addr=7 -> stall=1; holding stall until a wb with Rd=7, RegWrite=1 -> stall=0 in that cycle and rs2_data=wb.Result.
REQ-035 Same edge: ld_issue with ld_rd=9 and wb with Rd=9 -> busy[9]=1 next cycle, stall=1 when rs1_addr=9.
REQ-036 Set busy[3] and write reg[3]=0x12, then pulse rst asynchronously between edges -> outputs 0 immediately, busy[3]=0, reg[3]=0.
